// File: rtl/core_fetch_queue.sv
// Instruction fetch queue: issues word requests, tracks outstanding/stale responses, presents halfword pairs.
// Optional zero-latency path for responses into an empty queue: define CORE_FETCH_BYPASS_EN.
module core_fetch_queue #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned MAX_PENDING = 2,
  parameter logic [30:0] RESET_PC    = '0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch,
  input  logic [30:0] target,
  input  logic        fetch_gnt,
  input  logic        fetched,
  input  logic [31:0] fetch_data,
  output logic        fetch,
  output logic [29:0] addr,
  output logic        flush,
  output logic        lo_valid,
  output logic        hi_valid,
  output logic [15:0] lo_insn,
  output logic [15:0] hi_insn,
  output logic [30:0] lo_insn_pc,
  output logic [30:0] hi_insn_pc
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [31:0]   mem [DEPTH];
  logic [AW:0]   head, tail, occ;
  logic [CW-1:0] outst, stale;
  logic [29:0]   fptr, pc;
  logic          odd;
  logic          empty, can_fetch, grant, live, byp, push, pop_q, present, adv;
  logic [31:0]   word;

  assign occ   = tail - head;
  assign empty = (head == tail);

  // Stale requests still occupy a queue slot in the budget until they drain.
  assign can_fetch = ((CW + 1)'(occ) + (CW + 1)'(outst) < (CW + 1)'(DEPTH)) &&
                     (outst < CW'(MAX_PENDING));
  assign fetch = !rst && can_fetch;
  assign grant = fetch && fetch_gnt;
  assign addr  = branch ? target[30:1] : fptr;
  assign flush = branch;

  assign live = fetched && (stale == '0) && !branch;
`ifdef CORE_FETCH_BYPASS_EN
  assign byp = live && empty && !stall;
`else
  assign byp = 1'b0;
`endif
  assign push    = live && !byp;
  assign present = !branch && (!empty || byp);
  assign pop_q   = !empty && !stall && !branch;
  assign adv     = present && !stall;

  assign word       = empty ? fetch_data : mem[head[AW-1:0]];
  assign lo_valid   = present && !odd;
  assign hi_valid   = present;
  assign lo_insn    = word[15:0];
  assign hi_insn    = word[31:16];
  assign lo_insn_pc = {pc, 1'b0};
  assign hi_insn_pc = {pc, 1'b1};

  always_ff @(posedge clk) begin
    if (push) mem[tail[AW-1:0]] <= fetch_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      outst <= '0;
      stale <= '0;
      fptr  <= RESET_PC[30:1];
      pc    <= RESET_PC[30:1];
      odd   <= RESET_PC[0];
    end else begin
      outst <= outst + CW'(grant) - CW'(fetched);
      if (branch) begin
        // A response landing this cycle is already retired, so it is not counted as stale.
        stale <= outst - CW'(fetched);
        tail  <= head;
        pc    <= target[30:1];
        odd   <= target[0];
        fptr  <= target[30:1] + 30'(grant);
      end else begin
        if (fetched && (stale != '0)) stale <= stale - 1'b1;
        if (push)  tail <= tail + 1'b1;
        if (pop_q) head <= head + 1'b1;
        if (adv) begin
          pc  <= pc + 1'b1;
          odd <= 1'b0;
        end
        fptr <= fptr + 30'(grant);
      end
    end
  end

endmodule

// File: doc/core_fetch_queue.md
CORE_FETCH_QUEUE -- requirements
Module: core_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning fetch-queue entries (32-bit words), power of two, >= 2.
REQ-002 SHALL have parameter MAX_PENDING, default 2, meaning maximum outstanding memory requests, 1..DEPTH.
REQ-003 SHALL have parameter RESET_PC, default 0, meaning 31-bit halfword pointer fetched after reset.
REQ-004 SHALL have a port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have a port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have a port stall, input, 1 bit: decode not accepting the current pair.
REQ-007 SHALL have a port branch, input, 1 bit: redirect fetch this cycle.
REQ-008 SHALL have a port target, input, 31 bits: halfword pointer of the redirect; bit 0 selects the halfword.
REQ-009 SHALL have a port fetch_gnt, input, 1 bit: memory accepted the request presented this cycle.
REQ-010 SHALL have a port fetched, input, 1 bit: in-order response valid.
REQ-011 SHALL have a port fetch_data, input, 32 bits: response word; [15:0] lo halfword, [31:16] hi halfword.
REQ-012 SHALL have a port fetch, output, 1 bit: request valid.
REQ-013 SHALL have a port addr, output, 30 bits: word address of the request.
REQ-014 SHALL have a port flush, output, 1 bit: downstream pipeline flush.
REQ-015 SHALL have ports lo_valid and hi_valid, output, 1 bit each: the corresponding halfword is a valid instruction.
REQ-016 SHALL have ports lo_insn and hi_insn, output, 16 bits each: instruction halfwords.
REQ-017 SHALL have ports lo_insn_pc and hi_insn_pc, output, 31 bits each: halfword pointers of the two instructions.

Function
REQ-018 SHALL assert flush combinationally equal to branch.
REQ-019 SHALL keep a fetch pointer (word address), incremented by 1 on each cycle with fetch && fetch_gnt; on branch it SHALL take target[30:1].
REQ-020 SHALL drive addr from target[30:1] when branch is high, else from the fetch pointer.
REQ-021 SHALL assert fetch only when (occupied entries + outstanding requests) < DEPTH and outstanding < MAX_PENDING; stale requests count toward both limits.
REQ-022 SHALL hold fetch and addr stable until fetch_gnt, except when branch is asserted.
REQ-023 SHALL track outstanding requests: +1 on grant, -1 on fetched; simultaneous grant and response leave the count unchanged.
REQ-024 On branch, SHALL empty the queue and mark every outstanding request as stale, excluding any response arriving in the same cycle.
REQ-025 SHALL discard responses while the stale count is nonzero, decrementing it; other responses SHALL be written at the queue tail.
REQ-026 SHALL present the head word when the queue is nonempty: lo_insn_pc = {word,0}, hi_insn_pc = {word,1}.
REQ-027 SHALL clear lo_valid for the first word after a branch to an odd target, or after reset to an odd RESET_PC; all other words SHALL have both valids high.
REQ-028 SHALL pop the head when it is presented and stall is low; with stall high, the outputs SHALL hold.
REQ-029 SHALL drive lo_valid = hi_valid = 0 when the queue is empty or branch is high.
REQ-030 SHALL use wrap-around head and tail pointers with one extra bit to distinguish full from empty; push and pop in the same cycle SHALL keep occupancy constant.
REQ-031 SHALL never overflow; a non-stale response arriving while full is impossible by REQ-021.

Reset
REQ-032 While rst is high: queue empty, outstanding = 0, stale = 0, fetch = 0, valids = 0, fetch pointer = RESET_PC[30:1], odd-start flag = RESET_PC[0].
REQ-033 Reset asserted mid-transaction SHALL abandon all outstanding requests; responses after release are the memory's responsibility to suppress.
REQ-034 The first request SHALL issue in the first cycle after rst deasserts.

Configuration
REQ-035 Macro CORE_FETCH_BYPASS_EN: when defined, a non-stale response arriving with the queue empty and stall low SHALL be presented in the same cycle and not written into the queue (zero latency).
REQ-036 Without CORE_FETCH_BYPASS_EN, a response SHALL appear at the outputs no earlier than the cycle after fetched.

Verification
REQ-037 Reset release, RESET_PC=0, gnt always 1, 1-cycle response latency, stall=0 -> addr sequence 0,1,2..., words presented in order with pcs {n,0}/{n,1}, both valids 1.
REQ-038 stall held 10 cycles, DEPTH=4 -> queue fills to 4, fetch drops to 0, no data lost; stall release -> 4 pops on consecutive cycles.
REQ-039 Branch to target 0x21 with 2 requests outstanding -> flush=1 that cycle, addr=0x10, next 2 responses discarded, first presented word 0x10 with lo_valid=0 and hi_valid=1.
REQ-040 Branch in the same cycle as fetched -> that response discarded, stale count = outstanding - 1.
REQ-041 fetch_gnt held 0 for 5 cycles -> fetch=1 and addr constant throughout.
REQ-042 With and without CORE_FETCH_BYPASS_EN, empty queue, fetched at cycle t -> valids high at cycle t (bypass) versus t+1 (no bypass).
